// File: rtl/hier_lane_pipe.sv
// hier_lane_pipe: a valid/ready pipeline built from DEPTH identical register-slice
// instances. It carries LANES XOR'd bit-channels plus a WIDTH-bit side bus and counts output transfers.

module hier_lane_stage #(
    parameter int LANES = 2,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             src_valid,
    input  logic [LANES-1:0] src_q,
    input  logic [WIDTH-1:0] src_bus,
    output logic             valid,
    output logic [LANES-1:0] q,
    output logic [WIDTH-1:0] bus
);

    // The data registers move only with a valid word, so a bubble keeps the old payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
            bus   <= '0;
        end else if (load) begin
            valid <= src_valid;
            if (src_valid) begin
                q   <= src_q;
                bus <= src_bus;
            end
        end
    end

endmodule

module hier_lane_pipe #(
    parameter int LANES = 2,
    parameter int WIDTH = 2,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LANES-1:0] in_a,
    input  logic [LANES-1:0] in_b,
    input  logic [WIDTH-1:0] in_bus,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LANES-1:0] out_q,
    output logic [WIDTH-1:0] out_bus,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0][LANES-1:0] q;
    logic [DEPTH-1:0][WIDTH-1:0] bus;
    logic [DEPTH:0]              ready;
    logic [DEPTH-1:0]            src_valid;
    logic [DEPTH-1:0][LANES-1:0] src_q;
    logic [DEPTH-1:0][WIDTH-1:0] src_bus;

    // Ready ripples back from the output; an empty stage always accepts, which collapses bubbles.
    always_comb begin
        ready        = '0;
        ready[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            ready[k] = ~valid[k] | ready[k + 1];
        end
    end

    always_comb begin
        src_valid    = '0;
        src_q        = '0;
        src_bus      = '0;
        src_valid[0] = in_valid;
        src_q[0]     = in_a ^ in_b;
        src_bus[0]   = in_bus;
        for (int k = 1; k < DEPTH; k++) begin
            src_valid[k] = valid[k - 1];
            src_q[k]     = q[k - 1];
            src_bus[k]   = bus[k - 1];
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        hier_lane_stage #(
            .LANES (LANES),
            .WIDTH (WIDTH)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .load      (ready[k]),
            .src_valid (src_valid[k]),
            .src_q     (src_q[k]),
            .src_bus   (src_bus[k]),
            .valid     (valid[k]),
            .q         (q[k]),
            .bus       (bus[k])
        );
    end

    assign in_ready  = ready[0];
    assign out_valid = valid[DEPTH-1];
    assign out_q     = q[DEPTH-1];
    assign out_bus   = bus[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule
